// File: rtl/thermo_pkg.sv
// Shared types and sizing helpers for the multi-zone thermostat controller.
package thermo_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      HEAT    = 2'b01,
      COOL    = 2'b10,
      LOCKOUT = 2'b11
   } zone_state_e;

   function automatic int cnt_max(input int min_on, input int min_off);
      return (min_on > min_off) ? min_on : min_off;
   endfunction

   // Counter width able to hold the saturation value max(min_on, min_off).
   function automatic int cnt_w(input int min_on, input int min_off);
      return $clog2(cnt_max(min_on, min_off) + 1);
   endfunction

endpackage

// File: rtl/thermo_zone_fsm.sv
// One zone: hysteresis thresholds, state machine and min-on/min-off dwell counter.
module thermo_zone_fsm
   import thermo_pkg::*;
#(
   parameter int TEMP_W      = 8,
   parameter int TOL_W       = 5,
   parameter int MIN_ON_CYC  = 16,
   parameter int MIN_OFF_CYC = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [TEMP_W-1:0] current_temp,
   input  logic [TEMP_W-1:0] desired_temp,
   input  logic [TOL_W-1:0]  temp_tolerance,
   output logic              heater_on,
   output logic              cooler_on,
   output zone_state_e       zone_state
);

   localparam int CNT_MAX = cnt_max(MIN_ON_CYC, MIN_OFF_CYC);
   localparam int CNT_W   = cnt_w(MIN_ON_CYC, MIN_OFF_CYC);
   localparam int SW      = TEMP_W + 2;

   zone_state_e       state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic signed [SW-1:0] temp_s, des_s, lo, hi;
   logic              on_done, off_done;

   // Two guard bits keep lo below zero and hi above full scale representable,
   // so out-of-range thresholds simply never trigger.
   assign temp_s = $signed(SW'(current_temp));
   assign des_s  = $signed(SW'(desired_temp));
   assign lo     = des_s - $signed(SW'(temp_tolerance));
   assign hi     = des_s + $signed(SW'(temp_tolerance));

   assign on_done  = (cnt >= CNT_W'(MIN_ON_CYC - 1));
   assign off_done = (cnt >= CNT_W'(MIN_OFF_CYC - 1));

   always_comb begin
      // NOTE: default assigned first so every path drives state_next and no latch is inferred.
      state_next = state;
      case (state)
         IDLE: begin
            if (enable && (temp_s < lo))      state_next = HEAT;
            else if (enable && (temp_s > hi)) state_next = COOL;
         end
         HEAT: begin
            if (!enable || ((temp_s >= des_s) && on_done)) state_next = LOCKOUT;
         end
         COOL: begin
            if (!enable || ((temp_s <= des_s) && on_done)) state_next = LOCKOUT;
         end
         LOCKOUT: begin
            if (off_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so state and cnt both update from pre-edge values.
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)          cnt <= '0;
         else if (cnt != CNT_W'(CNT_MAX))  cnt <= cnt + CNT_W'(1);
      end
   end

   assign heater_on  = (state == HEAT);
   assign cooler_on  = (state == COOL);
   assign zone_state = state;

endmodule

// File: rtl/thermo_ctrl_multizone.sv
// Multi-zone heater/cooler controller: replicates one zone FSM per zone and packs the buses.
module thermo_ctrl_multizone
   import thermo_pkg::*;
#(
   parameter int NUM_ZONES   = 4,
   parameter int TEMP_W      = 8,
   parameter int TOL_W       = 5,
   parameter int MIN_ON_CYC  = 16,
   parameter int MIN_OFF_CYC = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUM_ZONES*TEMP_W-1:0] current_temp,
   input  logic [NUM_ZONES*TEMP_W-1:0] desired_temp,
   input  logic [TOL_W-1:0]            temp_tolerance,
   output logic [NUM_ZONES-1:0]        heater_on,
   output logic [NUM_ZONES-1:0]        cooler_on,
   output logic [2*NUM_ZONES-1:0]      zone_state
);

   for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
      zone_state_e zs;

      thermo_zone_fsm #(
         .TEMP_W      (TEMP_W),
         .TOL_W       (TOL_W),
         .MIN_ON_CYC  (MIN_ON_CYC),
         .MIN_OFF_CYC (MIN_OFF_CYC)
      ) u_zone (
         .clk            (clk),
         .reset          (reset),
         .enable         (enable),
         .current_temp   (current_temp[z*TEMP_W +: TEMP_W]),
         .desired_temp   (desired_temp[z*TEMP_W +: TEMP_W]),
         .temp_tolerance (temp_tolerance),
         .heater_on      (heater_on[z]),
         .cooler_on      (cooler_on[z]),
         .zone_state     (zs)
      );

      assign zone_state[2*z +: 2] = zs;
   end

endmodule

// File: tb/tb_thermo_ctrl_multizone.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural zone model.
module tb_thermo_ctrl_multizone;

   localparam int NZ   = 2;
   localparam int TW   = 8;
   localparam int TOLW = 5;
   localparam int MON  = 4;
   localparam int MOFF = 3;
   localparam int OW   = 4 * NZ;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 enable;
   logic [NZ*TW-1:0]     current_temp;
   logic [NZ*TW-1:0]     desired_temp;
   logic [TOLW-1:0]      temp_tolerance;
   logic [NZ-1:0]        heater_on;
   logic [NZ-1:0]        cooler_on;
   logic [2*NZ-1:0]      zone_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: mode 0 idle, 1 heating, 2 cooling, 3 locked out; age = full cycles spent in mode.
   int m_mode[NZ];
   int m_age[NZ];

   thermo_ctrl_multizone #(
      .NUM_ZONES   (NZ),
      .TEMP_W      (TW),
      .TOL_W       (TOLW),
      .MIN_ON_CYC  (MON),
      .MIN_OFF_CYC (MOFF)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .current_temp   (current_temp),
      .desired_temp   (desired_temp),
      .temp_tolerance (temp_tolerance),
      .heater_on      (heater_on),
      .cooler_on      (cooler_on),
      .zone_state     (zone_state)
   );

   always #5 clk = ~clk;

   task automatic model_edge();
      for (int z = 0; z < NZ; z++) begin
         int t, d, tol, nm;
         t   = int'(current_temp[z*TW +: TW]);
         d   = int'(desired_temp[z*TW +: TW]);
         tol = int'(temp_tolerance);
         if (reset) begin
            m_mode[z] = 0;
            m_age[z]  = 0;
         end else begin
            m_age[z] = m_age[z] + 1;
            nm = m_mode[z];
            case (m_mode[z])
               0: if (enable && t < d - tol) nm = 1;
                  else if (enable && t > d + tol) nm = 2;
               1: if (!enable || (t >= d && m_age[z] >= MON)) nm = 3;
               2: if (!enable || (t <= d && m_age[z] >= MON)) nm = 3;
               default: if (m_age[z] >= MOFF) nm = 0;
            endcase
            if (nm != m_mode[z]) begin
               m_mode[z] = nm;
               m_age[z]  = 0;
            end
         end
      end
   endtask

   function automatic logic [OW-1:0] model_bus();
      logic [NZ-1:0]   h, c;
      logic [2*NZ-1:0] s;
      h = '0;
      c = '0;
      s = '0;
      for (int z = 0; z < NZ; z++) begin
         h[z]       = (m_mode[z] == 1);
         c[z]       = (m_mode[z] == 2);
         s[2*z +: 2] = 2'(m_mode[z]);
      end
      return {h, c, s};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_zone(input int z, input int t, input int d);
      current_temp[z*TW +: TW] = TW'(t);
      desired_temp[z*TW +: TW] = TW'(d);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      enable         = 1'b1;
      temp_tolerance = TOLW'(2);
      set_zone(0, 60, 70);
      set_zone(1, 80, 70);
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({heater_on, cooler_on, zone_state} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %b expected %b", {heater_on, cooler_on, zone_state}, {OW{1'b0}});
      end
      reset = 1'b0;
      set_zone(0, 70, 70);
      set_zone(1, 70, 70);
      tick();
      n_checks++;
      if ({heater_on, cooler_on, zone_state} !== model_bus()) begin
         n_fail++;
         $display("FAIL reset_idle: got %b expected %b", {heater_on, cooler_on, zone_state}, model_bus());
      end
   endtask

   task automatic test_heat_trigger();
      set_zone(0, 60, 70);
      set_zone(1, 70, 70);
      tick();
      n_checks++;
      if ({heater_on, cooler_on, zone_state} !== {2'b01, 2'b00, 4'b0001}) begin
         n_fail++;
         $display("FAIL heat_trigger: got %b expected %b", {heater_on, cooler_on, zone_state}, 8'b01000001);
      end
      n_checks++;
      if ({heater_on, cooler_on, zone_state} !== model_bus()) begin
         n_fail++;
         $display("FAIL heat_trigger_model: got %b expected %b", {heater_on, cooler_on, zone_state}, model_bus());
      end
   endtask

   // Continues from the heating zone 0 left by test_heat_trigger.
   task automatic test_min_on_lockout();
      logic [1:0] exp_z0 [8] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 8; i++) begin
         if (i == 0) set_zone(0, 70, 70);
         if (i == 4) set_zone(0, 60, 70);
         tick();
         n_checks++;
         if (zone_state !== {2'b00, exp_z0[i]}) begin
            n_fail++;
            $display("FAIL min_on_lockout[%0d]: got %b expected %b", i, zone_state, {2'b00, exp_z0[i]});
         end
         n_checks++;
         if ({heater_on, cooler_on, zone_state} !== model_bus()) begin
            n_fail++;
            $display("FAIL min_on_lockout_model[%0d]: got %b expected %b", i, {heater_on, cooler_on, zone_state}, model_bus());
         end
      end
   endtask

   task automatic test_hysteresis();
      int         temps  [9] = '{72, 68, 73, 71, 71, 71, 71, 70, 70};
      logic [1:0] exp_z0 [9] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
      set_zone(0, 70, 70);
      set_zone(1, 70, 70);
      do_reset();
      for (int i = 0; i < 9; i++) begin
         set_zone(0, temps[i], 70);
         tick();
         n_checks++;
         if ({cooler_on[0], zone_state[1:0]} !== {exp_z0[i] == 2'd2, exp_z0[i]}) begin
            n_fail++;
            $display("FAIL hysteresis[%0d]: got cool=%b state=%b expected state=%b", i, cooler_on[0], zone_state[1:0], exp_z0[i]);
         end
         n_checks++;
         if ({heater_on, cooler_on, zone_state} !== model_bus()) begin
            n_fail++;
            $display("FAIL hysteresis_model[%0d]: got %b expected %b", i, {heater_on, cooler_on, zone_state}, model_bus());
         end
      end
   endtask

   task automatic test_threshold_edges();
      set_zone(0, 0, 1);
      set_zone(1, 255, 254);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (zone_state !== 4'b0000) begin
            n_fail++;
            $display("FAIL threshold_no_trigger[%0d]: got %b expected %b", i, zone_state, 4'b0000);
         end
      end
      set_zone(0, 0, 3);
      tick();
      n_checks++;
      if ({heater_on, zone_state} !== {2'b01, 4'b0001}) begin
         n_fail++;
         $display("FAIL threshold_heat: got heat=%b state=%b expected heat=01 state=0001", heater_on, zone_state);
      end
      n_checks++;
      if ({heater_on, cooler_on, zone_state} !== model_bus()) begin
         n_fail++;
         $display("FAIL threshold_model: got %b expected %b", {heater_on, cooler_on, zone_state}, model_bus());
      end
   endtask

   task automatic test_enable_drop();
      logic       en     [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [1:0] exp_z0 [9] = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2};
      enable = 1'b1;
      set_zone(0, 70, 70);
      set_zone(1, 70, 70);
      do_reset();
      set_zone(0, 80, 70);
      for (int i = 0; i < 9; i++) begin
         enable = en[i];
         tick();
         n_checks++;
         if ({cooler_on[0], zone_state[1:0]} !== {exp_z0[i] == 2'd2, exp_z0[i]}) begin
            n_fail++;
            $display("FAIL enable_drop[%0d]: got cool=%b state=%b expected state=%b", i, cooler_on[0], zone_state[1:0], exp_z0[i]);
         end
         n_checks++;
         if ({heater_on, cooler_on, zone_state} !== model_bus()) begin
            n_fail++;
            $display("FAIL enable_drop_model[%0d]: got %b expected %b", i, {heater_on, cooler_on, zone_state}, model_bus());
         end
      end
      enable = 1'b1;
   endtask

   task automatic test_back_to_back();
      set_zone(0, 60, 70);
      set_zone(1, 60, 70);
      do_reset();
      tick();
      tick();
      n_checks++;
      if (zone_state !== 4'b0101) begin
         n_fail++;
         $display("FAIL b2b_both_heat: got %b expected %b", zone_state, 4'b0101);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if ({heater_on, cooler_on, zone_state} !== '0) begin
         n_fail++;
         $display("FAIL b2b_reset_mid_heat: got %b expected %b", {heater_on, cooler_on, zone_state}, {OW{1'b0}});
      end
      reset = 1'b0;
      set_zone(1, 80, 70);
      tick();
      n_checks++;
      if ({heater_on, cooler_on, zone_state} !== {2'b01, 2'b10, 4'b1001}) begin
         n_fail++;
         $display("FAIL b2b_simultaneous: got %b expected %b", {heater_on, cooler_on, zone_state}, 8'b01101001);
      end
      n_checks++;
      if ((heater_on & cooler_on) !== '0) begin
         n_fail++;
         $display("FAIL b2b_exclusive: got heat=%b cool=%b expected no overlap", heater_on, cooler_on);
      end
   endtask

   task automatic test_random();
      int des [NZ];
      int tmp [NZ];
      for (int z = 0; z < NZ; z++) begin
         des[z] = 70;
         tmp[z] = 70;
      end
      for (int i = 0; i < 800; i++) begin
         for (int z = 0; z < NZ; z++) begin
            if ($urandom_range(0, 15) == 0) begin
               case ($urandom_range(0, 5))
                  0:       des[z] = 0;
                  1:       des[z] = 255;
                  2:       des[z] = int'($urandom_range(1, 3));
                  default: des[z] = int'($urandom_range(0, 255));
               endcase
            end
            tmp[z] = des[z] + int'($urandom_range(0, 20)) - 10;
            if (tmp[z] < 0)   tmp[z] = 0;
            if (tmp[z] > 255) tmp[z] = 255;
            set_zone(z, tmp[z], des[z]);
         end
         if ($urandom_range(0, 49) == 0) temp_tolerance = TOLW'($urandom_range(0, 31));
         enable = ($urandom_range(0, 9) != 0);
         reset  = ($urandom_range(0, 99) == 0);
         tick();
         n_checks++;
         if ({heater_on, cooler_on, zone_state} !== model_bus()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %b expected %b", i, {heater_on, cooler_on, zone_state}, model_bus());
         end
         n_checks++;
         if ((heater_on & cooler_on) !== '0) begin
            n_fail++;
            $display("FAIL random_exclusive[%0d]: got heat=%b cool=%b", i, heater_on, cooler_on);
         end
      end
      reset  = 1'b0;
      enable = 1'b1;
   endtask

   initial begin
      reset          = 1'b1;
      enable         = 1'b1;
      current_temp   = '0;
      desired_temp   = '0;
      temp_tolerance = TOLW'(2);
      for (int z = 0; z < NZ; z++) begin
         m_mode[z] = 0;
         m_age[z]  = 0;
      end
      test_reset();
      test_heat_trigger();
      test_min_on_lockout();
      test_hysteresis();
      test_threshold_edges();
      test_enable_drop();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
